// File: rtl/axi4_burst_mem_slave.sv
`timescale 1ns/1ps
// axi4_burst_mem_slave
//   AXI4 (full) memory-mapped responder backed by a word-addressed register
//   array of 2**C_MEM_WORDS_LOG2 words. Supports FIXED/INCR/WRAP bursts of
//   1..256 beats. The write and read channels run independent FSMs, and each
//   channel allows one outstanding transaction.
//
// Handshake rule: a beat or command transfers on a rising ACLK edge where
//   both VALID and READY are high. A VALID, once raised, is held with its
//   payload stable until that edge.
//
// Ports
//   ACLK, ARESET             clock, asynchronous active-high reset
//   S_AXI_AW*                write command (ID, ADDR, LEN, SIZE, BURST, VALID/READY)
//   S_AXI_W*                 write data (DATA, STRB, LAST, VALID/READY)
//   S_AXI_B*                 write response (ID, RESP, VALID/READY)
//   S_AXI_AR*                read command (ID, ADDR, LEN, SIZE, BURST, VALID/READY)
//   S_AXI_R*                 read data (ID, DATA, RESP, LAST, VALID/READY)
module axi4_burst_mem_slave #(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_MEM_WORDS_LOG2   = 6
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                      S_AXI_AWLEN,
  input  logic [2:0]                      S_AXI_AWSIZE,
  input  logic [1:0]                      S_AXI_AWBURST,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WLAST,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]                      S_AXI_ARLEN,
  input  logic [2:0]                      S_AXI_ARSIZE,
  input  logic [1:0]                      S_AXI_ARBURST,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RLAST,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  localparam int IW    = C_S_AXI_ID_WIDTH;
  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int AW    = C_S_AXI_ADDR_WIDTH;
  localparam int LG    = C_MEM_WORDS_LOG2;
  localparam int DEPTH = 1 << LG;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  // Address of the beat following addr. FIXED holds, WRAP stays inside the
  // (LEN+1)*4-byte aligned window, everything else increments by one word.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] addr,
                                              input logic [7:0]    len,
                                              input logic [1:0]    burst);
    logic [AW-1:0] mask;
    logic [AW-1:0] res;
    mask = ((AW'(len) + AW'(1)) << 2) - AW'(1);
    case (burst)
      2'b00:   res = addr;
      2'b10:   res = (addr & ~mask) | ((addr + AW'(4)) & mask);
      default: res = addr + AW'(4);
    endcase
    return res;
  endfunction

  function automatic logic burst_err(input logic [2:0] size,
                                     input logic [1:0] burst,
                                     input logic [7:0] len);
    logic bad_wrap;
    bad_wrap = (burst == 2'b10) &&
               !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    return (size != 3'b010) || (burst == 2'b11) || bad_wrap;
  endfunction

  logic [DW-1:0] mem [DEPTH];

  // ---------------------------------------------------------------- write
  w_state_t      w_state, w_state_nxt;
  logic [IW-1:0] aw_id_q;
  logic [AW-1:0] w_addr_q;
  logic [7:0]    aw_len_q;
  logic [1:0]    aw_burst_q;
  logic          aw_err_q;
  logic [7:0]    w_cnt_q;
  logic          wlast_err_q;
  logic [1:0]    bresp_q;

  logic aw_hs, w_hs, w_final, wlast_bad;
  logic [LG-1:0] w_idx;

  assign aw_hs     = (w_state == W_IDLE) && S_AXI_AWVALID;
  assign w_hs      = (w_state == W_DATA) && S_AXI_WVALID;
  assign w_final   = (w_cnt_q == aw_len_q);
  assign wlast_bad = (S_AXI_WLAST != w_final);
  assign w_idx     = w_addr_q[LG+1:2];

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) w_state <= W_IDLE;
    else        w_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_state_nxt = W_DATA;
      W_DATA:  if (w_hs && w_final) w_state_nxt = W_RESP;
      W_RESP:  if (S_AXI_BREADY) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_BVALID  = 1'b0;
    case (w_state)
      W_IDLE:  S_AXI_AWREADY = 1'b1;
      W_DATA:  S_AXI_WREADY  = 1'b1;
      W_RESP:  S_AXI_BVALID  = 1'b1;
      default: S_AXI_AWREADY = 1'b0;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_id_q     <= '0;
      w_addr_q    <= '0;
      aw_len_q    <= '0;
      aw_burst_q  <= '0;
      aw_err_q    <= 1'b0;
      w_cnt_q     <= '0;
      wlast_err_q <= 1'b0;
      bresp_q     <= RESP_OKAY;
    end else if (aw_hs) begin
      aw_id_q     <= S_AXI_AWID;
      w_addr_q    <= S_AXI_AWADDR;
      aw_len_q    <= S_AXI_AWLEN;
      aw_burst_q  <= S_AXI_AWBURST;
      aw_err_q    <= burst_err(S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWLEN);
      w_cnt_q     <= '0;
      wlast_err_q <= 1'b0;
    end else if (w_hs) begin
      w_addr_q <= next_addr(w_addr_q, aw_len_q, aw_burst_q);
      w_cnt_q  <= w_cnt_q + 8'd1;
      if (wlast_bad) wlast_err_q <= 1'b1;
      // Response is settled on the last beat, including that beat's WLAST.
      if (w_final)
        bresp_q <= (aw_err_q || wlast_err_q || wlast_bad) ? RESP_SLVERR : RESP_OKAY;
    end
  end

  // Storage has no reset; error bursts consume beats without writing.
  always_ff @(posedge ACLK) begin
    if (w_hs && !aw_err_q) begin
      for (int b = 0; b < DW/8; b++) begin
        if (S_AXI_WSTRB[b]) mem[w_idx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
      end
    end
  end

  assign S_AXI_BID   = aw_id_q;
  assign S_AXI_BRESP = bresp_q;

  // ----------------------------------------------------------------- read
  r_state_t      r_state, r_state_nxt;
  logic [IW-1:0] rid_q;
  logic [AW-1:0] r_addr_q;
  logic [7:0]    ar_len_q;
  logic [1:0]    ar_burst_q;
  logic          ar_err_q;
  logic [7:0]    r_cnt_q;
  logic [DW-1:0] rdata_q;
  logic          rlast_q;
  logic [1:0]    rresp_q;

  logic ar_hs, r_hs, r_final, ar_err;
  logic [AW-1:0] r_next;
  logic [LG-1:0] ar_idx, r_next_idx;

  assign ar_hs      = (r_state == R_IDLE) && S_AXI_ARVALID;
  assign r_hs       = (r_state == R_DATA) && S_AXI_RREADY;
  assign r_final    = (r_cnt_q == ar_len_q);
  assign ar_err     = burst_err(S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARLEN);
  assign r_next     = next_addr(r_addr_q, ar_len_q, ar_burst_q);
  assign ar_idx     = S_AXI_ARADDR[LG+1:2];
  assign r_next_idx = r_next[LG+1:2];

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_state <= R_IDLE;
    else        r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_nxt = R_DATA;
      R_DATA:  if (r_hs && r_final) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    S_AXI_ARREADY = 1'b0;
    S_AXI_RVALID  = 1'b0;
    case (r_state)
      R_IDLE:  S_AXI_ARREADY = 1'b1;
      R_DATA:  S_AXI_RVALID  = 1'b1;
      default: S_AXI_ARREADY = 1'b0;
    endcase
  end

  // RDATA is loaded from the array with a nonblocking read, so a write to the
  // same word on the same edge is not visible until the next load.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rid_q      <= '0;
      r_addr_q   <= '0;
      ar_len_q   <= '0;
      ar_burst_q <= '0;
      ar_err_q   <= 1'b0;
      r_cnt_q    <= '0;
      rdata_q    <= '0;
      rlast_q    <= 1'b0;
      rresp_q    <= RESP_OKAY;
    end else if (ar_hs) begin
      rid_q      <= S_AXI_ARID;
      r_addr_q   <= S_AXI_ARADDR;
      ar_len_q   <= S_AXI_ARLEN;
      ar_burst_q <= S_AXI_ARBURST;
      ar_err_q   <= ar_err;
      r_cnt_q    <= '0;
      rdata_q    <= ar_err ? '0 : mem[ar_idx];
      rlast_q    <= (S_AXI_ARLEN == 8'd0);
      rresp_q    <= ar_err ? RESP_SLVERR : RESP_OKAY;
    end else if (r_hs) begin
      if (r_final) begin
        rlast_q <= 1'b0;
      end else begin
        r_addr_q <= r_next;
        r_cnt_q  <= r_cnt_q + 8'd1;
        rdata_q  <= ar_err_q ? '0 : mem[r_next_idx];
        rlast_q  <= ((r_cnt_q + 8'd1) == ar_len_q);
      end
    end
  end

  assign S_AXI_RID   = rid_q;
  assign S_AXI_RDATA = rdata_q;
  assign S_AXI_RRESP = rresp_q;
  assign S_AXI_RLAST = rlast_q;

endmodule

// File: doc/axi4_burst_mem_slave.md
Name: axi4_burst_mem_slave

Overview:
- AXI4 (full) memory-mapped responder backed by an internal word-addressed register array.
- It is the slave end of the burst traffic issued by the AXI4 master BFM in the block-design bench.
- Supports INCR, WRAP and FIXED bursts of 1..256 beats, with independent, concurrent write and read channels.
- AWLOCK/AWCACHE/AWPROT/AWQOS/AWREGION/user signals (and AR equivalents) are not ports; the wrapper leaves them unconnected and they have no effect.

Parameters:
- C_S_AXI_ID_WIDTH, 1, width of AWID/BID/ARID/RID.
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 32, byte address width.
- C_MEM_WORDS_LOG2, 6, memory depth is 2**C_MEM_WORDS_LOG2 words (64 words = 256 bytes).

Ports:
- ACLK  in  1  clock; all logic is on the rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- S_AXI_AWID  in  ID_WIDTH  write ID.
- S_AXI_AWADDR  in  ADDR_WIDTH  write start byte address.
- S_AXI_AWLEN  in  8  beats-1.
- S_AXI_AWSIZE  in  3  beat size.
- S_AXI_AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP.
- S_AXI_AWVALID  in  1.
- S_AXI_AWREADY  out  1.
- S_AXI_WDATA  in  32.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WLAST  in  1.
- S_AXI_WVALID  in  1.
- S_AXI_WREADY  out  1.
- S_AXI_BID  out  ID_WIDTH.
- S_AXI_BRESP  out  2.
- S_AXI_BVALID  out  1.
- S_AXI_BREADY  in  1.
- S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARVALID  in  (same widths as the AW equivalents).
- S_AXI_ARREADY  out  1.
- S_AXI_RID  out  ID_WIDTH.
- S_AXI_RDATA  out  32.
- S_AXI_RRESP  out  2.
- S_AXI_RLAST  out  1.
- S_AXI_RVALID  out  1.
- S_AXI_RREADY  in  1.

Behaviour:
- Reset (asynchronous, ARESET=1):
  - Both FSMs go to IDLE.
  - AWREADY=1, ARREADY=1; WREADY, BVALID, RVALID, RLAST = 0.
  - BRESP, RRESP, RDATA, BID, RID = 0.
  - Memory contents are not reset (X until written).
  - Reset mid-burst abandons the burst immediately; no response is issued.
- Burst legality check, evaluated at AW/AR handshake:
  - The burst is in error if any of: SIZE != 3'b010; BURST == 2'b11; BURST == WRAP with LEN not in {1,3,7,15}.
  - Error write: all beats are accepted and discarded, BRESP=2'b10 (SLVERR).
  - Error read: LEN+1 beats are returned with RDATA=0 and RRESP=2'b10.
- Address rules:
  - Byte address bits [1:0] are ignored.
  - Word index = addr[C_MEM_WORDS_LOG2+1:2]; higher address bits alias (modulo depth).
  - Next address per beat:
    - FIXED: unchanged.
    - INCR: addr+4.
    - WRAP: mask = (LEN+1)*4-1; next = (addr & ~mask) | ((addr+4) & mask).
- Write FSM W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: AWREADY=1. On AWVALID, latch ID/addr/len/burst/error, set beat count to 0, go to W_DATA; AWREADY drops the next cycle.
  - W_DATA: WREADY=1. Each W handshake writes the bytes enabled by WSTRB (unless the burst is in error) and advances the address and count. When count==LEN, go to W_RESP.
  - WLAST mismatch: if WLAST=1 on a beat other than count==LEN, or WLAST=0 on the final beat, BRESP=SLVERR. Termination still follows LEN; beats after an early WLAST are still consumed.
  - W_RESP: BVALID=1 with BID = latched ID. It holds until BREADY, then goes to W_IDLE with AWREADY=1 the next cycle.
  - Minimum write turnaround: AW at cycle 0, first WREADY at cycle 1, BVALID the cycle after the last beat.
- Read FSM R_IDLE -> R_DATA:
  - R_IDLE: ARREADY=1. AR handshake latches the fields; RVALID=1 the next cycle with RDATA = mem[start] registered, RLAST = (LEN==0).
  - R_DATA: on an R handshake with count<LEN, RDATA and RLAST load the next word in the same edge. RVALID stays high, giving one beat per cycle.
  - The handshake on the RLAST beat returns to R_IDLE: RVALID=0, ARREADY=1.
  - While RREADY=0, RDATA/RLAST/RRESP/RID are held stable.
- Concurrency:
  - Read and write channels are fully independent.
  - A write and a read-load of the same word on the same edge: the read returns the pre-write data.
  - Only one outstanding transaction per channel; the AW/AR ready signal stays low until that channel's FSM returns to IDLE.

Test Plan:
- Reset: assert ARESET at a random time during a 16-beat read -> RVALID=0, RLAST=0, ARREADY=1, AWREADY=1, BVALID=0 while reset is held; the next transaction completes normally.
- Bench sequence: INCR write, LEN=15, addr 0x0, words 0x00abcdef..0xFFFFFFFF, then WRAP read, LEN=15, addr 0x0 -> BRESP=00, 16 identical words in order, RLAST only on beat 16, RRESP=00 on every beat.
- WRAP order: preload words 0..3 = 0xA0..0xA3; WRAP read LEN=3 at 0x08 -> RDATA sequence 0xA2, 0xA3, 0xA0, 0xA1.
- FIXED write LEN=3 to 0x10 with data 1,2,3,4, then single read of 0x10 -> 0x00000004; word 0x14 unchanged.
- WSTRB: word 0x20 = 0xFFFFFFFF; write 0xDEADBEEF with WSTRB=4'b0011 -> read 0xFFFFBEEF.
- Errors and backpressure:
  - AWSIZE=3'b001, LEN=1 -> BRESP=10 and memory unchanged.
  - Hold BREADY=0 for 5 cycles -> BVALID stays 1, AWREADY stays 0 until the handshake.
  - Read with RREADY toggling 1/0 -> no beat lost or duplicated.
